// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers; result lands 33 cycles after start.
// Radix-2 shift-add multiply and restoring divide on a shared 64-bit accumulator; busy stalls the pipeline.
module muldiv_unit #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [1:0]      op,
    input  logic            start,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic            s,
    output logic [SIZE-1:0] x,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(SIZE);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic [2*SIZE-1:0] r_acc;
    logic [SIZE-1:0]   r_opd;
    logic [SIZE-1:0]   r_a;
    logic              r_bzero;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [SIZE-1:0]   r_hi;
    logic [SIZE-1:0]   r_lo;
    logic              r_done;

    logic [SIZE-1:0]   w_a_abs;
    logic [SIZE-1:0]   w_b_abs;
    logic [SIZE:0]     w_mul_sum;
    logic [SIZE:0]     w_div_diff;
    logic [2*SIZE-1:0] w_acc_next;
    logic [2*SIZE-1:0] w_prod;
    logic [SIZE-1:0]   w_quo;
    logic [SIZE-1:0]   w_rem;

    assign w_a_abs = (op[0] && a[SIZE-1]) ? -a : a;
    assign w_b_abs = (op[0] && b[SIZE-1]) ? -b : b;

    // Multiply: r_opd is the multiplicand, multiplier sits in the low half and shifts out.
    // Divide: r_opd is the divisor, remainder in the high half, quotient shifts into the low half.
    assign w_mul_sum  = {1'b0, r_acc[2*SIZE-1:SIZE]} + {1'b0, (r_acc[0] ? r_opd : {SIZE{1'b0}})};
    assign w_div_diff = r_acc[2*SIZE-1:SIZE-1] - {1'b0, r_opd};

    always_comb begin
        w_acc_next = {w_mul_sum, r_acc[SIZE-1:1]};
        if (r_op[1]) begin
            if (w_div_diff[SIZE])
                w_acc_next = {r_acc[2*SIZE-2:0], 1'b0};
            else
                w_acc_next = {w_div_diff[SIZE-1:0], r_acc[SIZE-2:0], 1'b1};
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[SIZE-1:0] : r_acc[SIZE-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*SIZE-1:SIZE] : r_acc[2*SIZE-1:SIZE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_a     <= '0;
            r_bzero <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_acc   <= {{SIZE{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
                        r_opd   <= op[1] ? w_b_abs : w_a_abs;
                        r_a     <= a;
                        r_bzero <= (b == {SIZE{1'b0}});
                        r_neg_q <= op[0] & (a[SIZE-1] ^ b[SIZE-1]);
                        r_neg_r <= op[0] & a[SIZE-1];
                    end else begin
                        if (wr_hi) r_hi <= a;
                        if (wr_lo) r_lo <= a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(SIZE-1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (!r_op[1]) begin
                        r_hi <= w_prod[2*SIZE-1:SIZE];
                        r_lo <= w_prod[SIZE-1:0];
                    end else if (r_bzero) begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        r_hi <= r_a;
                        r_lo <= {SIZE{1'b1}};
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x    = s ? r_hi : r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;
    logic        start = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic        s = 1'b0;
    logic [31:0] x;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.SIZE(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .s(s), .x(x), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_x(input string tag);
        s = 1'b1; #1; check({tag, "_hi"}, x, m_hi);
        s = 1'b0; #1; check({tag, "_lo"}, x, m_lo);
    endtask

    // Returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] res;
        sa = 64'(signed'(av));
        sb = 64'(signed'(bv));
        case (o)
            2'b00: res = {32'b0, av} * {32'b0, bv};
            2'b01: res = sa * sb;
            default: begin
                if (bv == 32'd0) res = {av, 32'hFFFF_FFFF};
                else if (o == 2'b10) res = {av % bv, av / bv};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issues one op; when noisy, pokes start/wr_lo/operands mid-run and wr_lo with start.
    // Returns in the done cycle so a caller can chain a back-to-back start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit noisy, input string tag);
        logic [63:0] exp;
        int n;
        exp = ref_op(o, av, bv);
        op = o; a = av; b = bv; start = 1'b1; wr_lo = noisy;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 2 && noisy) begin
                start = 1'b1; wr_lo = 1'b1; wr_hi = 1'b1;
                op = 2'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
            end
            if (n == 5) begin
                check({tag, "_done_low"}, 32'(done), 32'd0);
                check_x({tag, "_hold"});
            end
            tick();
            n++;
        end
        start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
        check({tag, "_busy_len"}, 32'(n), 32'd33);
        check({tag, "_done"}, 32'(done), 32'd1);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check_x(tag);
    endtask

    task automatic idle_tick(input string tag);
        tick();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_x("rst");
        reset = 1'b0;
        tick();

        // Reset during RUN discards the op immediately.
        op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check_x("midrst");
        reset = 1'b0;
        tick();

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check("multu_max_hi_lit", m_hi, 32'hFFFF_FFFE);
        idle_tick("multu_max");
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        check("mult_neg_lo_lit", m_lo, 32'hFFFF_FFEB);
        idle_tick("mult_neg");
        do_op(2'b01, 32'd5, 32'd6, 1'b1, "mult_5x6");
        idle_tick("mult_5x6");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        check("div_neg_lo_lit", m_lo, 32'hFFFF_FFFD);
        // Back-to-back: start issued in the done cycle.
        do_op(2'b10, 32'd100, 32'd7, 1'b1, "divu_b2b");
        check("divu_b2b_lo_lit", m_lo, 32'd14);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_lo_lit", m_lo, 32'h8000_0000);
        idle_tick("div_ovf");
        do_op(2'b10, 32'h1234, 32'd0, 1'b0, "divu_zero");
        idle_tick("divu_zero");
        do_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, "div_zero");
        idle_tick("div_zero");

        // MTHI/MTLO in IDLE.
        a = 32'hCAFE_BABE; wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        m_hi = 32'hCAFE_BABE;
        check_x("mthi");
        a = 32'h0BAD_F00D; wr_hi = 1'b1; wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;
        check_x("mthilo");

        for (int i = 0; i < 10; i++) begin
            logic [1:0] ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            do_op(ro, ra, rb, 1'($urandom), "rand");
            if ($urandom_range(0, 1) == 1) idle_tick("rand");
        end
        idle_tick("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation did not finish, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
